// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - stall bit indices, polarity constants and stall encodings for pipe_ctrl
package pipe_ctrl_pkg;

   localparam int STALL_BITS = 6;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   localparam logic STOP       = 1'b1;
   localparam logic NO_STOP    = 1'b0;
   localparam logic RST_ENABLE = 1'b0;

   localparam logic [STALL_BITS-1:0] STALL_ENC_MEM  = 6'b011111;
   localparam logic [STALL_BITS-1:0] STALL_ENC_EX   = 6'b001111;
   localparam logic [STALL_BITS-1:0] STALL_ENC_ID   = 6'b000111;
   localparam logic [STALL_BITS-1:0] STALL_ENC_IF   = 6'b000011;
   localparam logic [STALL_BITS-1:0] STALL_ENC_NONE = 6'b000000;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_IF,
      SRC_ID,
      SRC_EX,
      SRC_MEM
   } stall_src_e;

   function automatic logic [STALL_BITS-1:0] stall_encode(input stall_src_e src);
      logic [STALL_BITS-1:0] enc;
      case (src)
         SRC_MEM: enc = STALL_ENC_MEM;
         SRC_EX:  enc = STALL_ENC_EX;
         SRC_ID:  enc = STALL_ENC_ID;
         SRC_IF:  enc = STALL_ENC_IF;
         default: enc = STALL_ENC_NONE;
      endcase
      return enc;
   endfunction

endpackage

// File: rtl/pipe_ctrl_redirect.sv
// rtl/pipe_ctrl_redirect.sv - pending PC redirect and stale-fetch discard tracking
module pipe_ctrl_redirect
   import pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   input  logic [ADDR_W-1:0] target,
   input  logic              pc_stall,
   input  logic              if_busy,
   input  logic              if_done,
   output logic              pc_redirect,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              discard_q
);

   // A fresh acceptance always wins over the handshake clear, so the youngest target survives.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         pc_redirect <= 1'b0;
         redirect_pc <= '0;
         discard_q   <= 1'b0;
      end else begin
         if (accept) begin
            pc_redirect <= 1'b1;
            redirect_pc <= target;
         end else if (pc_stall == NO_STOP) begin
            pc_redirect <= 1'b0;
         end

         if (accept && if_busy && !if_done) begin
            discard_q <= 1'b1;
         end else if (if_done) begin
            discard_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32I pipeline stall/flush controller; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int STALL_W = STALL_BITS,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_stall_req,
   input  logic               id_stall_req,
   input  logic               ex_stall_req,
   input  logic               mem_stall_req,
   input  logic               if_busy,
   input  logic               if_done,
   input  logic               ex_branch_taken,
   input  logic [ADDR_W-1:0]  ex_branch_target,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic               pc_redirect,
   output logic [ADDR_W-1:0]  redirect_pc,
   output logic               if_discard
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_stall_cycles,
   output logic [31:0]        perf_flushes
`endif
);

   logic               accept;
   logic               discard_q;
   logic               in_reset;
   stall_src_e         src;
   logic [STALL_W-1:0] stall_raw;

   assign in_reset = (rst == RST_ENABLE);

   // ID/IF requests during an accepted branch come from wrong-path instructions.
   always_comb begin
      accept = ex_branch_taken & ~mem_stall_req & ~ex_stall_req;
      src    = SRC_NONE;
      if (mem_stall_req) begin
         src = SRC_MEM;
      end else if (ex_stall_req) begin
         src = SRC_EX;
      end else if (id_stall_req && !accept) begin
         src = SRC_ID;
      end else if (if_stall_req && !accept) begin
         src = SRC_IF;
      end
      stall_raw = stall_encode(src);
      if (discard_q) begin
         stall_raw[STALL_PC] = STOP;
         stall_raw[STALL_IF] = STOP;
      end
   end

   assign stall      = in_reset ? '0 : stall_raw;
   assign flush      = accept & ~in_reset;
   assign if_discard = discard_q & if_done;

   pipe_ctrl_redirect #(
      .ADDR_W (ADDR_W)
   ) u_redirect (
      .clk         (clk),
      .rst         (rst),
      .accept      (accept),
      .target      (ex_branch_target),
      .pc_stall    (stall[STALL_PC]),
      .if_busy     (if_busy),
      .if_done     (if_done),
      .pc_redirect (pc_redirect),
      .redirect_pc (redirect_pc),
      .discard_q   (discard_q)
   );

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         perf_stall_cycles <= '0;
         perf_flushes      <= '0;
      end else begin
         if (stall[STALL_PC] && perf_stall_cycles != '1) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
         if (accept && perf_flushes != '1) begin
            perf_flushes <= perf_flushes + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl (honours PIPE_CTRL_PERF_EN)
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_stall_req = 1'b0, id_stall_req = 1'b0, ex_stall_req = 1'b0, mem_stall_req = 1'b0;
   logic        if_busy = 1'b0, if_done = 1'b0, ex_branch_taken = 1'b0;
   logic [31:0] ex_branch_target = '0;
   logic [5:0]  stall;
   logic        flush, pc_redirect, if_discard;
   logic [31:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cycles, perf_flushes;
   int          m_psc = 0, m_pfl = 0;
`endif

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .if_stall_req     (if_stall_req),
      .id_stall_req     (id_stall_req),
      .ex_stall_req     (ex_stall_req),
      .mem_stall_req    (mem_stall_req),
      .if_busy          (if_busy),
      .if_done          (if_done),
      .ex_branch_taken  (ex_branch_taken),
      .ex_branch_target (ex_branch_target),
      .stall            (stall),
      .flush            (flush),
      .pc_redirect      (pc_redirect),
      .redirect_pc      (redirect_pc),
      .if_discard       (if_discard)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cycles(perf_stall_cycles),
      .perf_flushes     (perf_flushes)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
   task automatic drive(input logic ifs, input logic ids, input logic exs, input logic mems,
                        input logic busy, input logic done, input logic taken,
                        input logic [31:0] tgt);
      @(posedge clk);
      #1;
      if_stall_req = ifs; id_stall_req = ids; ex_stall_req = exs; mem_stall_req = mems;
      if_busy = busy; if_done = done; ex_branch_taken = taken; ex_branch_target = tgt;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   // Reference model: pipeline depth frozen by the oldest stalling stage, plus pending redirect/discard.
   logic        m_redir = 1'b0, m_disc = 1'b0;
   logic [31:0] m_pc = '0;

   always @(negedge clk) begin
      int   depth;
      logic acc;
      if (!rst) begin
         chk("m_stall", {26'd0, stall}, 32'd0);
         chk("m_flush", {31'd0, flush}, 32'd0);
         chk("m_pc_redirect", {31'd0, pc_redirect}, 32'd0);
         chk("m_redirect_pc", redirect_pc, 32'd0);
         chk("m_if_discard", {31'd0, if_discard}, 32'd0);
         m_redir = 1'b0; m_disc = 1'b0; m_pc = '0;
`ifdef PIPE_CTRL_PERF_EN
         m_psc = 0; m_pfl = 0;
`endif
      end else begin
         acc   = ex_branch_taken && !mem_stall_req && !ex_stall_req;
         depth = mem_stall_req ? 5 : ex_stall_req ? 4 :
                 (id_stall_req && !acc) ? 3 : (if_stall_req && !acc) ? 2 : 0;
         if (m_disc && depth < 2) depth = 2;
`ifdef PIPE_CTRL_PERF_EN
         chk("m_perf_stall", perf_stall_cycles, m_psc);
         chk("m_perf_flush", perf_flushes, m_pfl);
         if (depth > 0) m_psc++;
         if (acc) m_pfl++;
`endif
         chk("m_stall", {26'd0, stall}, (32'd1 << depth) - 32'd1);
         chk("m_flush", {31'd0, flush}, {31'd0, acc});
         chk("m_pc_redirect", {31'd0, pc_redirect}, {31'd0, m_redir});
         if (m_redir) chk("m_redirect_pc", redirect_pc, m_pc);
         chk("m_if_discard", {31'd0, if_discard}, {31'd0, m_disc && if_done});
         if (acc) begin
            m_redir = 1'b1;
            m_pc    = ex_branch_target;
         end else if (depth == 0) begin
            m_redir = 1'b0;
         end
         if (acc && if_busy && !if_done) m_disc = 1'b1;
         else if (if_done)               m_disc = 1'b0;
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {26'd0, stall}, 32'd0);
      chk("rst_pc_redirect", {31'd0, pc_redirect}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // mem + id stall together: mem wins
      drive(0, 1, 0, 1, 0, 0, 0, 32'h0);
      @(negedge clk);
      chk("mem_id_stall", {26'd0, stall}, 32'h1f);
      chk("mem_id_flush", {31'd0, flush}, 32'd0);

      // id stall two cycles, then release
      drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
      @(negedge clk); chk("id_stall_c1", {26'd0, stall}, 32'h07);
      drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
      @(negedge clk); chk("id_stall_c2", {26'd0, stall}, 32'h07);
      idle();
      @(negedge clk); chk("id_release", {26'd0, stall}, 32'h00);

      // simple taken branch to 0x40
      drive(0, 1, 0, 0, 0, 0, 1, 32'h40);
      @(negedge clk);
      chk("br40_flush_T", {31'd0, flush}, 32'd1);
      chk("br40_stall_masked", {26'd0, stall}, 32'd0);
      chk("br40_redir_T", {31'd0, pc_redirect}, 32'd0);
      idle();
      @(negedge clk);
      chk("br40_redir_T1", {31'd0, pc_redirect}, 32'd1);
      chk("br40_pc_T1", redirect_pc, 32'h40);
      chk("br40_flush_T1", {31'd0, flush}, 32'd0);
      idle();
      @(negedge clk);
      chk("br40_redir_T2", {31'd0, pc_redirect}, 32'd0);

      // branch to 0x80 with a fetch in flight returning at T+3
      drive(0, 0, 0, 0, 1, 0, 1, 32'h80);
      @(negedge clk); chk("br80_flush_T", {31'd0, flush}, 32'd1);
      for (int i = 1; i <= 2; i++) begin
         drive(0, 0, 0, 0, 1, 0, 0, 32'h0);
         @(negedge clk);
         chk("br80_stall_hold", {26'd0, stall}, 32'h03);
         chk("br80_no_discard", {31'd0, if_discard}, 32'd0);
      end
      drive(0, 0, 0, 0, 1, 1, 0, 32'h0);
      @(negedge clk);
      chk("br80_stall_T3", {26'd0, stall}, 32'h03);
      chk("br80_discard_T3", {31'd0, if_discard}, 32'd1);
      chk("br80_redir_T3", {31'd0, pc_redirect}, 32'd1);
      idle();
      @(negedge clk);
      chk("br80_stall_T4", {26'd0, stall}, 32'h00);
      chk("br80_redir_T4", {31'd0, pc_redirect}, 32'd1);
      chk("br80_pc_T4", redirect_pc, 32'h80);
      idle();
      @(negedge clk); chk("br80_redir_T5", {31'd0, pc_redirect}, 32'd0);

      // branch blocked by mem stall for 3 cycles
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 0, 0, 1, 32'hc0);
         @(negedge clk);
         chk("memblk_flush", {31'd0, flush}, 32'd0);
         chk("memblk_stall", {26'd0, stall}, 32'h1f);
      end
      drive(0, 0, 0, 0, 0, 0, 1, 32'hc0);
      @(negedge clk); chk("memblk_accept", {31'd0, flush}, 32'd1);
      idle();
      @(negedge clk); chk("memblk_pc", redirect_pc, 32'hc0);
      idle();

      // youngest redirect wins; acceptance coincident with if_done sets no discard
      drive(0, 0, 0, 0, 1, 0, 1, 32'h100);
      drive(0, 0, 0, 0, 1, 1, 1, 32'h200);
      @(negedge clk);
      chk("young_flush", {31'd0, flush}, 32'd1);
      chk("young_stall", {26'd0, stall}, 32'h03);
      chk("young_discard", {31'd0, if_discard}, 32'd1);
      idle();
      @(negedge clk);
      chk("young_pc", redirect_pc, 32'h200);
      chk("young_stall_clear", {26'd0, stall}, 32'h00);
      idle();
      @(negedge clk); chk("young_redir_clear", {31'd0, pc_redirect}, 32'd0);

      // async reset with redirect and discard pending
      drive(0, 0, 0, 0, 1, 0, 1, 32'h300);
      drive(0, 0, 0, 0, 1, 1, 0, 32'h0);
      #2;
      chk("prerst_redir", {31'd0, pc_redirect}, 32'd1);
      chk("prerst_discard", {31'd0, if_discard}, 32'd1);
      rst = 1'b0;
      #1;
      chk("async_redir", {31'd0, pc_redirect}, 32'd0);
      chk("async_pc", redirect_pc, 32'd0);
      chk("async_stall", {26'd0, stall}, 32'd0);
      chk("async_discard", {31'd0, if_discard}, 32'd0);
      idle();
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("postrst_redir", {31'd0, pc_redirect}, 32'd0);
      chk("postrst_stall", {26'd0, stall}, 32'd0);
      idle();
      @(negedge clk);
      chk("postrst_redir2", {31'd0, pc_redirect}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline. It merges per-stage stall requests into the shared stall bus that freezes or bubbles the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It accepts taken-branch/jump redirects from EX, flushes wrong-path stages, and holds the redirect until the PC stage accepts it. It also tracks an in-flight instruction fetch that must be discarded after a redirect.

Parameters:
- STALL_W, 6, stall bus width; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- ADDR_W, 32, PC / redirect target width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- if_stall_req  in  1  IF waiting on memory.
- id_stall_req  in  1  load-use hazard in ID.
- ex_stall_req  in  1  EX needs an extra cycle.
- mem_stall_req  in  1  MEM load/store busy.
- if_busy  in  1  IF has a fetch outstanding.
- if_done  in  1  fetch data returns this cycle.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- ex_branch_target  in  ADDR_W  redirect target.
- stall  out  STALL_W  stall bus.
- flush  out  1  load bubbles into IF/ID and ID/EX this cycle.
- pc_redirect  out  1  PC must load redirect_pc.
- redirect_pc  out  ADDR_W  target.
- if_discard  out  1  drop the fetch returning this cycle.

Behaviour:
- Reset (rst==0, async): stall=0, flush=0, pc_redirect=0, redirect_pc=0, discard_q=0, if_discard=0.
- Stall encoding (combinational, highest stage wins):
  - mem → 011111
  - ex → 001111
  - id → 000111
  - if → 000011
  - none → 000000
- Bubble rule for downstream registers: stage register k inserts a bubble when stall[k]=1 and stall[k+1]=0; it holds when both are 1.
- Branch acceptance: accepted in cycle T iff ex_branch_taken=1 and mem_stall_req=0 and ex_stall_req=0.
  - While EX is frozen, the request is ignored; EX re-presents it every cycle until unfrozen.
- On acceptance in cycle T (combinational):
  - flush=1.
  - id_stall_req and if_stall_req are masked (wrong-path requests), so stall=000000 unless ex/mem also request.
- On acceptance, at the T edge (registered):
  - pc_redirect<=1, redirect_pc<=ex_branch_target.
  - If if_busy=1 and if_done=0 in T, discard_q<=1.
- Redirect handshake:
  - pc_redirect stays high until a cycle with stall[0]=0; it clears at the edge ending that cycle. PC loads redirect_pc in that same cycle.
  - A new acceptance while pc_redirect=1 overwrites redirect_pc (youngest wins) and keeps pc_redirect=1.
- Discard:
  - if_discard = discard_q & if_done (combinational).
  - discard_q clears at the edge of a cycle with if_done=1.
  - While discard_q=1, stall[0] and stall[1] are forced to 1 so PC does not issue before the stale fetch retires.
- Simultaneous events:
  - Acceptance with if_done=1 in the same cycle: discard_q is not set. That fetch is dropped because flush=1 bubbles IF/ID.
  - mem_stall_req together with ex_branch_taken: stall=011111 and no acceptance.
- Latency: stall/flush take effect in 0 cycles; redirect reaches the PC at the earliest 1 cycle after acceptance.
- Reset mid-operation clears all state, including pending redirect and discard.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flushes[31:0].
  - Both are saturating counters, reset to 0.
  - perf_stall_cycles counts cycles with stall[0]=1.
  - perf_flushes counts accepted branches.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared defines file: stall bit indices (STALL_PC..STALL_WB), Stop/NoStop, RstEnable-style polarity constant for the active-low reset, and the four stall encodings as named constants.
- Sub-module pipe_ctrl_redirect: holds pc_redirect/redirect_pc/discard_q and their handshake. The stall encoder stays in the top module.

Test Plan:
- mem_stall_req=1 with id_stall_req=1 → stall=011111, flush=0.
- id_stall_req=1 only, for 2 cycles → stall=000111 both cycles, then 000000.
- ex_branch_taken=1, target=0x0000_0040, if_busy=0, no stalls → flush=1 in T; pc_redirect=1 and redirect_pc=0x40 in T+1; cleared in T+2.
- Branch to 0x80 with if_busy=1; if_done arrives at T+3 → stall[1:0]=11 during T+1..T+3; if_discard=1 at T+3; pc_redirect held until T+4 and accepted then.
- ex_branch_taken=1 with mem_stall_req=1 for 3 cycles → no flush during those cycles; flush occurs in the first cycle mem_stall_req=0.
- rst pulsed low while pc_redirect=1 and discard_q=1 → all outputs 0 immediately (async), with no redirect after release.
